bob_ind_drain: RTL and testbench
================================

// Module: bob_ind_drain
// PURPOSE
//  In-order allocator and drainer for the BOB indirection table. Hands out
//  entry indices at the tail and clears each entry's ready bit through the
//  table's indirect write port. Polls the head entry through the table's
//  registered read port. Once the head's ready bit is set, presents its data
//  on a valid/ack output and retires it. Sits beside the BOB indirection table
//  as its consumer; producers fill entries through the table's data write port.
// PARAMETERS
//  ADDR_WIDTH  `bob_addr_width  index width
//  DATA_WIDTH  65               table entry width
//  ADDR_COUNT  `bob_count       entry count (need not be a power of 2)
// PORTS
//  clk             in   1           clock
//  rst             in   1           asynchronous reset, active-low
//  flush           in   1           synchronous discard of all entries
//  alloc_req       in   1           request one new index
//  alloc_gnt       out  1           grant; comb = alloc_req & ~full & ~flush
//  alloc_idx       out  ADDR_WIDTH  granted index (= tail)
//  tbl_writeI_wen  out  1           = alloc_gnt
//  tbl_writeI_addr out  ADDR_WIDTH  = tail
//  tbl_writeI_ready out 1           constant 0 (clears ready on allocate)
//  tbl_read_clkEn  out  1           load table read address
//  tbl_read_addr   out  ADDR_WIDTH  = head
//  tbl_read_data   in   DATA_WIDTH  entry data, 1 cycle after clkEn
//  tbl_read_ready  in   1           entry ready bit, 1 cycle after clkEn
//  out_valid       out  1           head entry presented
//  out_data        out  DATA_WIDTH  registered head data
//  out_idx         out  ADDR_WIDTH  registered head index
//  out_ack         in   1           consumer accepts; retire when out_valid
//  count           out  ADDR_WIDTH+1 entries currently allocated
// BEHAVIOUR
//  Reset (rst=0, async): head=tail=0, count=0, state=IDLE, out_valid=0,
//   out_data=0, out_idx=0.
//  full = (count==ADDR_COUNT). empty = (count==0).
//  Pointers wrap: index ADDR_COUNT-1 increments to 0.
//  Allocate: on grant edge, tail++.
//  Update: count_next = count + alloc_gnt - retire, where retire = HOLD & out_ack.
//   Alloc and retire in the same cycle leave count unchanged.
//   When full, the grant stays 0 even if a retire happens in that cycle.
//  FSM (tbl_read_clkEn is asserted only in the states below):
//   IDLE:  if ~empty, assert clkEn (addr=head) and go to CHECK; else stay.
//   CHECK: if tbl_read_ready=1, latch out_data<=tbl_read_data and
//          out_idx<=head, then go to HOLD.
//          Otherwise re-assert clkEn (addr=head) and stay; polls every cycle.
//   HOLD:  out_valid=1; out_data and out_idx stay stable until ack.
//          On out_ack: head++, count--, go to IDLE.
//  Timing: ready seen in CHECK at cycle N gives out_valid at N+1.
//   Best-case throughput is 1 retire per 3 cycles.
//  Entries do not collide: the drainer reads head only when ~empty, and
//   alloc writes tail only when ~full, so head!=tail whenever both are active.
//  flush (sync, priority over everything except reset):
//   head=tail=0, count=0, state=IDLE, out_valid=0.
//   alloc_gnt=0 and out_ack is ignored in the flush cycle.
//   Flush mid-HOLD drops the presented entry without retiring it.
//  Async reset mid-operation: all state returns to reset values immediately.
//   No outstanding table write is issued afterwards.
// TESTING
//  1 Reset, then alloc_req 1 cycle -> alloc_gnt=1, alloc_idx=0,
//    writeI_wen=1 with addr 0 and ready 0; count=1.
//  2 Entry 0 made ready 5 cycles after alloc -> CHECK polls continuously;
//    out_valid rises the cycle after ready is seen; out_idx=0, data matches;
//    ack -> count=0, state IDLE.
//  3 Hold alloc_req for 70 cycles with no ready ->
//    exactly ADDR_COUNT (64) grants; alloc_gnt=0 at count=64.
//  4 Full, head presented, out_ack together with alloc_req ->
//    no grant that cycle, count=63; next cycle grant of index 0 after wrap.
//  5 out_ack held low for 10 cycles in HOLD ->
//    out_valid, out_data and out_idx stable; no head advance.
//  6 flush during HOLD with out_ack=1 and alloc_req=1 ->
//    next cycle out_valid=0, count=0, head=tail=0, and no grant.

Source files
------------

// File: rtl/bob_ind_drain.sv
// bob_ind_drain
//
// In-order allocator and drainer for the BOB indirection table.
//   - Allocation side: hands out entry indices at the tail and clears each
//     newly allocated entry's ready bit through the table's indirect write
//     port (tbl_writeI_*).
//   - Drain side: polls the head entry through the table's registered read
//     port. Once the head's ready bit is seen, the entry is captured, presented
//     on out_valid/out_data/out_idx and retired when out_ack is given.
//   - Producers fill entries through the table's own data write port; this
//     block never writes entry data.
//
// Ports
//   clk, rst           clock, asynchronous active-low reset
//   flush              synchronous discard of every allocated entry
//   alloc_req/gnt/idx  allocation handshake; alloc_idx is the current tail
//   tbl_writeI_*       indirect write that clears ready on allocate
//   tbl_read_*         registered table read port (data one cycle after clkEn)
//   out_valid/data/idx head entry presentation, retired by out_ack
//   count              number of entries currently allocated
module bob_ind_drain #(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 65,
  parameter int unsigned ADDR_COUNT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,

  input  logic                  alloc_req,
  output logic                  alloc_gnt,
  output logic [ADDR_WIDTH-1:0] alloc_idx,

  output logic                  tbl_writeI_wen,
  output logic [ADDR_WIDTH-1:0] tbl_writeI_addr,
  output logic                  tbl_writeI_ready,

  output logic                  tbl_read_clkEn,
  output logic [ADDR_WIDTH-1:0] tbl_read_addr,
  input  logic [DATA_WIDTH-1:0] tbl_read_data,
  input  logic                  tbl_read_ready,

  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_idx,
  input  logic                  out_ack,

  output logic [ADDR_WIDTH:0]   count
);

  localparam logic [ADDR_WIDTH:0]   CountMax = (ADDR_WIDTH + 1)'(ADDR_COUNT);
  localparam logic [ADDR_WIDTH-1:0] IdxLast  = ADDR_WIDTH'(ADDR_COUNT - 1);

  typedef enum logic [1:0] {
    StIdle,
    StCheck,
    StHold
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] head_q, head_d;
  logic [ADDR_WIDTH-1:0] tail_q, tail_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;

  logic full;
  logic empty;
  logic retire;
  logic capture;

  // Pointers wrap explicitly so ADDR_COUNT need not be a power of two.
  function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] ptr);
    return (ptr == IdxLast) ? '0 : ptr + 1'b1;
  endfunction

  assign full  = (count_q == CountMax);
  assign empty = (count_q == '0);

  // Grant is decided on the current count only: a retire in the same cycle
  // does not open a slot until the next cycle.
  assign alloc_gnt = alloc_req & ~full & ~flush;
  assign retire    = (state_q == StHold) & out_ack & ~flush;
  assign capture   = (state_q == StCheck) & tbl_read_ready & ~flush;

  assign alloc_idx        = tail_q;
  assign tbl_writeI_wen   = alloc_gnt;
  assign tbl_writeI_addr  = tail_q;
  assign tbl_writeI_ready = 1'b0;
  assign tbl_read_addr    = head_q;

  assign out_data = data_q;
  assign out_idx  = idx_q;
  assign count    = count_q;

  // Pointer and occupancy bookkeeping.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (alloc_gnt) begin
        tail_d = ptr_inc(tail_q);
      end
      if (retire) begin
        head_d = ptr_inc(head_q);
      end
      unique case ({alloc_gnt, retire})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Head entry capture; contents hold while presented.
  always_comb begin
    data_d = data_q;
    idx_d  = idx_q;
    if (capture) begin
      data_d = tbl_read_data;
      idx_d  = head_q;
    end
  end

  // FSM: state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!empty) begin
            state_d = StCheck;
          end
        end
        StCheck: begin
          if (tbl_read_ready) begin
            state_d = StHold;
          end
        end
        StHold: begin
          if (out_ack) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // FSM: outputs. The read port is re-armed every cycle in CHECK until the
  // head reports ready, so a late producer is picked up one cycle later.
  always_comb begin
    tbl_read_clkEn = 1'b0;
    out_valid      = 1'b0;
    unique case (state_q)
      StIdle:  tbl_read_clkEn = ~empty & ~flush;
      StCheck: tbl_read_clkEn = ~tbl_read_ready & ~flush;
      StHold:  out_valid      = 1'b1;
      default: begin
        tbl_read_clkEn = 1'b0;
        out_valid      = 1'b0;
      end
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      data_q  <= '0;
      idx_q   <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: tb/tb_bob_ind_drain.sv
// Directed self-checking bench for bob_ind_drain. Contains a small behavioural
// model of the BOB indirection table (registered read port, indirect ready
// clear, producer data write) driven around the DUT.
module tb_bob_ind_drain;

  localparam int unsigned AW = 6;
  localparam int unsigned DW = 65;
  localparam int unsigned AC = 64;

  logic          clk;
  logic          rst;
  logic          flush;
  logic          alloc_req;
  logic          alloc_gnt;
  logic [AW-1:0] alloc_idx;
  logic          tbl_writeI_wen;
  logic [AW-1:0] tbl_writeI_addr;
  logic          tbl_writeI_ready;
  logic          tbl_read_clkEn;
  logic [AW-1:0] tbl_read_addr;
  logic [DW-1:0] tbl_read_data;
  logic          tbl_read_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_idx;
  logic          out_ack;
  logic [AW:0]   count;

  // Producer write port into the table model.
  logic          prod_wen;
  logic [AW-1:0] prod_addr;
  logic [DW-1:0] prod_data;

  int checks;
  int errors;

  bob_ind_drain #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .ADDR_COUNT(AC)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .flush            (flush),
    .alloc_req        (alloc_req),
    .alloc_gnt        (alloc_gnt),
    .alloc_idx        (alloc_idx),
    .tbl_writeI_wen   (tbl_writeI_wen),
    .tbl_writeI_addr  (tbl_writeI_addr),
    .tbl_writeI_ready (tbl_writeI_ready),
    .tbl_read_clkEn   (tbl_read_clkEn),
    .tbl_read_addr    (tbl_read_addr),
    .tbl_read_data    (tbl_read_data),
    .tbl_read_ready   (tbl_read_ready),
    .out_valid        (out_valid),
    .out_data         (out_data),
    .out_idx          (out_idx),
    .out_ack          (out_ack),
    .count            (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Table model.
  logic          ready_mem [AC];
  logic [DW-1:0] data_mem  [AC];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(AC); i++) begin
        ready_mem[i] <= 1'b0;
        data_mem[i]  <= '0;
      end
      tbl_read_data  <= '0;
      tbl_read_ready <= 1'b0;
    end else begin
      if (prod_wen) begin
        ready_mem[prod_addr] <= 1'b1;
        data_mem[prod_addr]  <= prod_data;
      end
      if (tbl_writeI_wen) begin
        ready_mem[tbl_writeI_addr] <= tbl_writeI_ready;
      end
      if (tbl_read_clkEn) begin
        tbl_read_data  <= data_mem[tbl_read_addr];
        tbl_read_ready <= ready_mem[tbl_read_addr];
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst       = 1'b0;
    flush     = 1'b0;
    alloc_req = 1'b0;
    out_ack   = 1'b0;
    prod_wen  = 1'b0;
    prod_addr = '0;
    prod_data = '0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic write_entry(input logic [AW-1:0] a, input logic [DW-1:0] d);
    prod_wen  = 1'b1;
    prod_addr = a;
    prod_data = d;
    step();
    prod_wen  = 1'b0;
    #1;
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!out_valid && n < 12) begin
      step();
      n++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL wait_valid: out_valid=%0b after %0d cycles, want 1", out_valid, n);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (count !== '0 || out_valid !== 1'b0 || alloc_idx !== '0 || tbl_read_addr !== '0) begin
      errors++;
      $display("FAIL reset_state: count=%0d valid=%0b tail=%0d head=%0d want 0 0 0 0",
               count, out_valid, alloc_idx, tbl_read_addr);
    end
    checks++;
    if (out_data !== '0 || out_idx !== '0 || tbl_read_clkEn !== 1'b0) begin
      errors++;
      $display("FAIL reset_regs: data=%0h idx=%0d clkEn=%0b want 0 0 0",
               out_data, out_idx, tbl_read_clkEn);
    end
    rst = 1'b1;
    step();
  endtask

  task automatic test_alloc();
    alloc_req = 1'b1;
    #1;
    checks++;
    if (alloc_gnt !== 1'b1 || alloc_idx !== 6'd0) begin
      errors++;
      $display("FAIL alloc_grant: gnt=%0b idx=%0d want 1 0", alloc_gnt, alloc_idx);
    end
    checks++;
    if (tbl_writeI_wen !== 1'b1 || tbl_writeI_addr !== 6'd0 || tbl_writeI_ready !== 1'b0) begin
      errors++;
      $display("FAIL alloc_writeI: wen=%0b addr=%0d ready=%0b want 1 0 0",
               tbl_writeI_wen, tbl_writeI_addr, tbl_writeI_ready);
    end
    step();
    alloc_req = 1'b0;
    #1;
    checks++;
    if (count !== 7'd1 || alloc_idx !== 6'd1 || tbl_read_clkEn !== 1'b1) begin
      errors++;
      $display("FAIL alloc_after: count=%0d tail=%0d clkEn=%0b want 1 1 1",
               count, alloc_idx, tbl_read_clkEn);
    end
  endtask

  task automatic test_drain();
    logic          poll_ok;
    logic          seen;
    logic [DW-1:0] d;
    d = 65'h1_0123_4567_89AB_CDEF;
    poll_ok = 1'b1;
    repeat (4) begin
      step();
      if (tbl_read_clkEn !== 1'b1 || tbl_read_addr !== 6'd0 || out_valid !== 1'b0) poll_ok = 1'b0;
    end
    checks++;
    if (poll_ok !== 1'b1) begin
      errors++;
      $display("FAIL drain_poll: continuous polling of head 0 got %0b want 1", poll_ok);
    end
    write_entry(6'd0, d);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (tbl_read_ready) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    checks++;
    if (seen !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_seen: seen=%0b valid=%0b want 1 0", seen, out_valid);
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || out_idx !== 6'd0 || out_data !== d) begin
      errors++;
      $display("FAIL drain_present: valid=%0b idx=%0d data=%0h want 1 0 %0h",
               out_valid, out_idx, out_data, d);
    end
    out_ack = 1'b1;
    step();
    out_ack = 1'b0;
    #1;
    checks++;
    if (count !== '0 || out_valid !== 1'b0 || tbl_read_clkEn !== 1'b0 ||
        tbl_read_addr !== 6'd1) begin
      errors++;
      $display("FAIL drain_retire: count=%0d valid=%0b clkEn=%0b head=%0d want 0 0 0 1",
               count, out_valid, tbl_read_clkEn, tbl_read_addr);
    end
  endtask

  task automatic test_fill();
    int   grants;
    logic order_ok;
    apply_reset();
    rst = 1'b1;
    step();
    grants    = 0;
    order_ok  = 1'b1;
    alloc_req = 1'b1;
    #1;
    for (int i = 0; i < 70; i++) begin
      if (alloc_gnt) begin
        if (alloc_idx !== AW'(grants)) order_ok = 1'b0;
        grants++;
      end
      step();
    end
    checks++;
    if (grants != 64 || order_ok !== 1'b1) begin
      errors++;
      $display("FAIL fill_grants: grants=%0d in_order=%0b want 64 1", grants, order_ok);
    end
    checks++;
    if (count !== 7'd64 || alloc_gnt !== 1'b0) begin
      errors++;
      $display("FAIL fill_full: count=%0d gnt=%0b want 64 0", count, alloc_gnt);
    end
  endtask

  task automatic test_full_ack_alloc();
    logic [DW-1:0] d;
    d = 65'h0_FEED_FACE_0BAD_F00D;
    write_entry(6'd0, d);
    wait_valid();
    checks++;
    if (out_idx !== 6'd0 || out_data !== d) begin
      errors++;
      $display("FAIL full_present: idx=%0d data=%0h want 0 %0h", out_idx, out_data, d);
    end
    out_ack = 1'b1;
    #1;
    checks++;
    if (alloc_gnt !== 1'b0) begin
      errors++;
      $display("FAIL full_ack_gnt: gnt=%0b want 0", alloc_gnt);
    end
    step();
    out_ack = 1'b0;
    #1;
    checks++;
    if (count !== 7'd63 || alloc_gnt !== 1'b1 || alloc_idx !== 6'd0 || tbl_read_addr !== 6'd1) begin
      errors++;
      $display("FAIL full_wrap: count=%0d gnt=%0b tail=%0d head=%0d want 63 1 0 1",
               count, alloc_gnt, alloc_idx, tbl_read_addr);
    end
    step();
    alloc_req = 1'b0;
    #1;
    checks++;
    if (count !== 7'd64 || alloc_idx !== 6'd1) begin
      errors++;
      $display("FAIL full_refill: count=%0d tail=%0d want 64 1", count, alloc_idx);
    end
  endtask

  task automatic test_hold_stable();
    logic [DW-1:0] d;
    logic          stable;
    d = 65'h1_AAAA_5555_3333_CCCC;
    write_entry(6'd1, d);
    wait_valid();
    checks++;
    if (out_idx !== 6'd1 || out_data !== d) begin
      errors++;
      $display("FAIL hold_present: idx=%0d data=%0h want 1 %0h", out_idx, out_data, d);
    end
    stable = 1'b1;
    repeat (10) begin
      step();
      if (out_valid !== 1'b1 || out_idx !== 6'd1 || out_data !== d ||
          tbl_read_addr !== 6'd1 || count !== 7'd64 || tbl_read_clkEn !== 1'b0) stable = 1'b0;
    end
    checks++;
    if (stable !== 1'b1) begin
      errors++;
      $display("FAIL hold_stable: stable=%0b want 1 (valid=%0b idx=%0d head=%0d)",
               stable, out_valid, out_idx, tbl_read_addr);
    end
  endtask

  task automatic test_flush();
    flush     = 1'b1;
    out_ack   = 1'b1;
    alloc_req = 1'b1;
    #1;
    checks++;
    if (alloc_gnt !== 1'b0) begin
      errors++;
      $display("FAIL flush_gnt: gnt=%0b want 0", alloc_gnt);
    end
    step();
    flush     = 1'b0;
    out_ack   = 1'b0;
    alloc_req = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || count !== '0 || tbl_read_addr !== '0 || alloc_idx !== '0 ||
        tbl_read_clkEn !== 1'b0) begin
      errors++;
      $display("FAIL flush_state: valid=%0b count=%0d head=%0d tail=%0d clkEn=%0b want 0",
               out_valid, count, tbl_read_addr, alloc_idx, tbl_read_clkEn);
    end
    // Flush must also block a grant that would otherwise be legal.
    alloc_req = 1'b1;
    flush     = 1'b1;
    #1;
    checks++;
    if (alloc_gnt !== 1'b0) begin
      errors++;
      $display("FAIL flush_gnt_empty: gnt=%0b want 0", alloc_gnt);
    end
    step();
    flush = 1'b0;
    #1;
    checks++;
    if (count !== '0 || alloc_gnt !== 1'b1 || alloc_idx !== '0) begin
      errors++;
      $display("FAIL flush_after: count=%0d gnt=%0b tail=%0d want 0 1 0",
               count, alloc_gnt, alloc_idx);
    end
    step();
    alloc_req = 1'b0;
    #1;
    checks++;
    if (count !== 7'd1 || alloc_idx !== 6'd1) begin
      errors++;
      $display("FAIL flush_alloc: count=%0d tail=%0d want 1 1", count, alloc_idx);
    end
  endtask

  task automatic test_async_reset();
    alloc_req = 1'b1;
    step();
    step();
    #3;
    rst       = 1'b0;
    alloc_req = 1'b0;
    #1;
    checks++;
    if (count !== '0 || out_valid !== 1'b0 || alloc_idx !== '0 || tbl_read_addr !== '0 ||
        tbl_writeI_wen !== 1'b0 || tbl_read_clkEn !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: count=%0d valid=%0b tail=%0d head=%0d wen=%0b clkEn=%0b want 0",
               count, out_valid, alloc_idx, tbl_read_addr, tbl_writeI_wen, tbl_read_clkEn);
    end
    step();
    rst = 1'b1;
    step();
    checks++;
    if (tbl_writeI_wen !== 1'b0 || count !== '0) begin
      errors++;
      $display("FAIL async_after: wen=%0b count=%0d want 0 0", tbl_writeI_wen, count);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_alloc();
    test_drain();
    test_fill();
    test_full_ack_alloc();
    test_hold_stable();
    test_flush();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
